io_mailbox: RTL and testbench

IO_MAILBOX -- requirements
Module: io_mailbox

---
 rtl/io_mailbox.sv | 179 +++++++++++++++++
 tb/tb_io_mailbox.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/io_mailbox.sv
// io_mailbox: CPU-facing command mailbox with a small byte FIFO, an external
// output register and a synchronised external input byte. The CPU issues a
// command by toggling d3_s[7]; the block answers by toggling d3_e[7].
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for d3_s[7] != ack; latches opcode and data bytes
// EXEC  | performs the latched opcode on FIFO / d0_e / ext_out / err
// DONE  | toggles ack so the CPU sees completion, then back to IDLE
module io_mailbox #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] d0_s,
    input  logic [7:0] d1_s,
    input  logic [7:0] d2_s,
    input  logic [7:0] d3_s,
    input  logic [7:0] ext_in,
    output logic [7:0] d0_e,
    output logic [7:0] d1_e,
    output logic [7:0] d2_e,
    output logic [7:0] d3_e,
    output logic [7:0] ext_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_PUSH   = 3'b001;
    localparam logic [2:0] OP_POP    = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;
    localparam logic [2:0] OP_SETOUT = 3'b100;
    localparam logic [2:0] OP_PEEK   = 3'b101;

    logic [1:0]    state;
    logic [2:0]    op_q;
    logic [7:0]    data0_q;
    logic [7:0]    data1_q;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    rd_data;
    logic [7:0]    ext_out_q;
    logic          err;
    logic          ack;
    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [7:0]    mem [DEPTH];

    logic pending;
    logic fifo_empty;
    logic fifo_full;
    logic mem_we;

    // Port 2 and the unused command bits are deliberately ignored.
    logic unused_ok;
    assign unused_ok = ^{d2_s, d3_s[6:3]};

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign pending    = d3_s[7] ^ ack;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign mem_we     = (state == ST_EXEC) && (op_q == OP_PUSH) && !fifo_full;

    assign d0_e    = rd_data;
    assign d1_e    = {{(8 - CW){1'b0}}, count};
    assign d2_e    = sync2;
    assign d3_e    = {ack, 4'b0000, err, fifo_full, fifo_empty};
    assign ext_out = ext_out_q;

    // Command FSM, FIFO bookkeeping and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_NOP;
            data0_q   <= '0;
            data1_q   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            ext_out_q <= '0;
            err       <= 1'b0;
            ack       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        op_q    <= d3_s[2:0];
                        data0_q <= d0_s;
                        data1_q <= d1_s;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_DONE;
                    case (op_q)
                        OP_NOP: err <= 1'b0;
                        OP_PUSH: begin
                            if (fifo_full) begin
                                err <= 1'b1;
                            end else begin
                                wr_ptr <= ptr_next(wr_ptr);
                                count  <= count + 1'b1;
                                err    <= 1'b0;
                            end
                        end
                        OP_POP: begin
                            if (fifo_empty) begin
                                err <= 1'b1;
                            end else begin
                                rd_data <= mem[rd_ptr];
                                rd_ptr  <= ptr_next(rd_ptr);
                                count   <= count - 1'b1;
                                err     <= 1'b0;
                            end
                        end
                        OP_CLEAR: begin
                            count  <= '0;
                            rd_ptr <= '0;
                            wr_ptr <= '0;
                            err    <= 1'b0;
                        end
                        OP_SETOUT: begin
                            ext_out_q <= data1_q;
                            err       <= 1'b0;
                        end
                        OP_PEEK: begin
                            if (fifo_empty) begin
                                err <= 1'b1;
                            end else begin
                                rd_data <= mem[rd_ptr];
                                err     <= 1'b0;
                            end
                        end
                        default: err <= 1'b1;
                    endcase
                end
                ST_DONE: begin
                    ack   <= ~ack;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // FIFO storage; not reset, and a write is suppressed while reset is held
    // so an aborted PUSH leaves nothing behind.
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem[wr_ptr] <= data0_q;
        end
    end

    // Two-flop synchroniser for the asynchronous external input byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ext_in;
            sync2 <= sync1;
        end
    end

endmodule

// File: tb/tb_io_mailbox.sv
// Directed bench for io_mailbox at DEPTH=4 with hand-computed expectations.
module tb_io_mailbox;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_PUSH   = 3'b001;
    localparam logic [2:0] OP_POP    = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;
    localparam logic [2:0] OP_SETOUT = 3'b100;
    localparam logic [2:0] OP_PEEK   = 3'b101;
    localparam logic [2:0] OP_BAD7   = 3'b111;

    logic       clk;
    logic       reset;
    logic [7:0] d0_s, d1_s, d2_s, d3_s, ext_in;
    logic [7:0] d0_e, d1_e, d2_e, d3_e, ext_out;

    int n_cmp;
    int n_bad;

    io_mailbox #(.DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .d0_s    (d0_s),
        .d1_s    (d1_s),
        .d2_s    (d2_s),
        .d3_s    (d3_s),
        .ext_in  (ext_in),
        .d0_e    (d0_e),
        .d1_e    (d1_e),
        .d2_e    (d2_e),
        .d3_e    (d3_e),
        .ext_out (ext_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the ack toggle to match the request and check latency.
    task automatic wait_ack(input string tag, input int exp_edges);
        int edges;
        edges = 0;
        while ((d3_e[7] !== d3_s[7]) && (edges < 12)) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_lat"}, 8'(edges), 8'(exp_edges));
    endtask

    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        d0_s = a;
        d1_s = b;
        d3_s = {~d3_s[7], 4'b0000, op};
        wait_ack(tag, 3);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        d3_s  = 8'h00;
        reset = 1'b0;
        #1;
        chk("rst_d3e", d3_e, 8'h01);
        chk("rst_d1e", d1_e, 8'h00);
        chk("rst_d0e", d0_e, 8'h00);
        chk("rst_d2e", d2_e, 8'h00);
        chk("rst_ext", ext_out, 8'h00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        d0_s   = 8'h00;
        d1_s   = 8'h00;
        d2_s   = 8'h00;
        d3_s   = 8'h00;
        ext_in = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state and quiet idle afterwards.
        pulse_reset();
        repeat (5) @(negedge clk);
        chk("idle_d3e", d3_e, 8'h01);
        chk("idle_d1e", d1_e, 8'h00);

        // Single PUSH then POP.
        do_op("push_a5", OP_PUSH, 8'hA5, 8'h00);
        chk("push_a5_cnt", d1_e, 8'h01);
        chk("push_a5_d3e", d3_e, 8'h80);
        do_op("pop_a5", OP_POP, 8'h00, 8'h00);
        chk("pop_a5_d0e", d0_e, 8'hA5);
        chk("pop_a5_cnt", d1_e, 8'h00);
        chk("pop_a5_d3e", d3_e, 8'h01);

        // Fill to full, overflow, drain, underflow.
        for (int i = 1; i <= 4; i++) begin
            do_op("fill", OP_PUSH, 8'(i), 8'h00);
            chk("fill_cnt", d1_e, 8'(i));
        end
        chk("full_flag", {7'b0, d3_e[1]}, 8'h01);
        chk("full_empty", {7'b0, d3_e[0]}, 8'h00);
        do_op("ovf", OP_PUSH, 8'h05, 8'h00);
        chk("ovf_err", {7'b0, d3_e[2]}, 8'h01);
        chk("ovf_cnt", d1_e, 8'h04);
        for (int i = 1; i <= 4; i++) begin
            do_op("drain", OP_POP, 8'h00, 8'h00);
            chk("drain_d0e", d0_e, 8'(i));
            chk("drain_err", {7'b0, d3_e[2]}, 8'h00);
        end
        do_op("udf", OP_POP, 8'h00, 8'h00);
        chk("udf_err", {7'b0, d3_e[2]}, 8'h01);
        chk("udf_d0e", d0_e, 8'h04);
        chk("udf_empty", {7'b0, d3_e[0]}, 8'h01);

        // Pointer wrap via alternating PUSH/POP.
        for (int i = 10; i <= 15; i++) begin
            do_op("wrap_push", OP_PUSH, 8'(i), 8'h00);
            do_op("wrap_pop", OP_POP, 8'h00, 8'h00);
            chk("wrap_d0e", d0_e, 8'(i));
        end
        chk("wrap_cnt", d1_e, 8'h00);
        chk("wrap_err", {7'b0, d3_e[2]}, 8'h00);

        // SETOUT, illegal opcode, NOP clears err.
        do_op("setout", OP_SETOUT, 8'h00, 8'h3C);
        chk("setout_ext", ext_out, 8'h3C);
        do_op("bad7", OP_BAD7, 8'h00, 8'h00);
        chk("bad7_err", {7'b0, d3_e[2]}, 8'h01);
        chk("bad7_ext", ext_out, 8'h3C);
        chk("bad7_cnt", d1_e, 8'h00);
        do_op("nop", OP_NOP, 8'h00, 8'h00);
        chk("nop_err", {7'b0, d3_e[2]}, 8'h00);

        // PEEK, CLEAR, PEEK on empty.
        do_op("push77", OP_PUSH, 8'h77, 8'h00);
        do_op("peek", OP_PEEK, 8'h00, 8'h00);
        chk("peek_d0e", d0_e, 8'h77);
        chk("peek_cnt", d1_e, 8'h01);
        do_op("clear", OP_CLEAR, 8'h00, 8'h00);
        chk("clear_cnt", d1_e, 8'h00);
        chk("clear_d0e", d0_e, 8'h77);
        chk("clear_empty", {7'b0, d3_e[0]}, 8'h01);
        do_op("peek_mt", OP_PEEK, 8'h00, 8'h00);
        chk("peek_mt_err", {7'b0, d3_e[2]}, 8'h01);
        chk("peek_mt_d0e", d0_e, 8'h77);

        // Inputs changing during EXEC must not disturb the latched command.
        @(negedge clk);
        d0_s = 8'h11;
        d3_s = {~d3_s[7], 4'b0000, OP_PUSH};
        @(posedge clk);
        #1;
        d0_s = 8'h99;
        d3_s = {d3_s[7], 4'b0000, OP_POP};
        wait_ack("hold", 2);
        chk("hold_cnt", d1_e, 8'h01);
        do_op("hold_pop", OP_POP, 8'h00, 8'h00);
        chk("hold_d0e", d0_e, 8'h11);

        // External input synchroniser: two edges of latency.
        @(negedge clk);
        ext_in = 8'h5A;
        @(posedge clk);
        #1;
        chk("sync_1", d2_e, 8'h00);
        @(posedge clk);
        #1;
        chk("sync_2", d2_e, 8'h5A);

        // Reset during EXEC of a PUSH, then the held toggle re-executes.
        pulse_reset();
        @(negedge clk);
        d0_s = 8'h55;
        d3_s = 8'h81;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_cnt", d1_e, 8'h00);
        chk("abort_d3e", d3_e, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        wait_ack("replay", 3);
        chk("replay_cnt", d1_e, 8'h01);
        do_op("replay_pop", OP_POP, 8'h00, 8'h00);
        chk("replay_d0e", d0_e, 8'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
